// File: rtl/single_port_ram.sv
// Synchronous single-port RAM with a shared read/write address and a registered read port.
// Build option: define SP_RAM_READ_FIRST_EN for read-first same-address behaviour (default is write-first).
module single_port_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  we,
    output logic [DATA_WIDTH-1:0] q
);

    localparam logic [ADDR_WIDTH:0] DEPTH_W = DEPTH[ADDR_WIDTH:0];

    // Zero at time zero keeps the behavioural model and the netlist free of X.
    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};
    logic [DATA_WIDTH-1:0] q_reg;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  in_range;
    logic                  wr_en;

    always_comb begin
        in_range = ({1'b0, addr} < DEPTH_W);
        wr_en    = 1'b0;
        // An unknown we fails this test, so X/Z control never writes.
        if (we == 1'b1 && in_range) begin
            wr_en = 1'b1;
        end
        rd_word = '0;
        if (in_range) begin
            rd_word = mem[addr];
        end
    end

    // The array is deliberately outside the reset domain; only writes are gated.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            mem[addr] <= data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= '0;
        end else begin
`ifdef SP_RAM_READ_FIRST_EN
            q_reg <= rd_word;
`else
            if (wr_en) begin
                q_reg <= data;
            end else begin
                q_reg <= rd_word;
            end
`endif
        end
    end

    assign q = q_reg;

endmodule

// File: tb/tb_single_port_ram.sv
// Directed bench for single_port_ram: reset, write/readback, overwrite, top address, reset mid-run.
module tb_single_port_ram;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  addr = '0;
    logic [31:0] data = '0;
    logic        we = 1'b0;
    logic [31:0] q;

    int n_cmp = 0;
    int n_err = 0;

    single_port_ram dut (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (addr),
        .data  (data),
        .we    (we),
        .q     (q)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_for(input int i);
        logic [31:0] k;
        k = 32'h9E3779B9;
        return 32'h12153524 ^ (k * i);
    endfunction

    task automatic check(input string tag, input logic [31:0] exp);
        n_cmp++;
        assert (q === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, q, exp);
        end
    endtask

    task automatic step(input logic w, input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        we   = w;
        addr = a;
        data = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp;

        // Reset held with an active write request: nothing may land in memory.
        we   = 1'b1;
        addr = 10'd0;
        data = 32'hFFFF_FFFF;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("reset_hold_q", 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        we    = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_read0", 32'h0);

        for (int i = 0; i < 32; i++) begin
            step(1'b1, 10'(i), word_for(i));
`ifdef SP_RAM_READ_FIRST_EN
            exp = 32'h0;
`else
            exp = word_for(i);
`endif
            check($sformatf("write_%0d", i), exp);
        end

        for (int i = 0; i < 32; i++) begin
            step(1'b0, 10'(i), 32'hFFFF_FFFF);
            check($sformatf("read_%0d", i), word_for(i));
        end
        step(1'b0, 10'd32, 32'h0);
        check("read_unwritten_32", 32'h0);

        step(1'b1, 10'd5, 32'hDEAD_BEEF);
`ifdef SP_RAM_READ_FIRST_EN
        exp = word_for(5);
`else
        exp = 32'hDEAD_BEEF;
`endif
        check("overwrite_a", exp);
        step(1'b1, 10'd5, 32'h0000_0001);
`ifdef SP_RAM_READ_FIRST_EN
        exp = 32'hDEAD_BEEF;
`else
        exp = 32'h0000_0001;
`endif
        check("overwrite_b", exp);
        step(1'b0, 10'd5, 32'h0);
        check("overwrite_read", 32'h0000_0001);

        step(1'b1, 10'd1023, 32'hA5A5_A5A5);
`ifdef SP_RAM_READ_FIRST_EN
        exp = 32'h0;
`else
        exp = 32'hA5A5_A5A5;
`endif
        check("top_write", exp);
        step(1'b0, 10'd1023, 32'h0);
        check("top_read", 32'hA5A5_A5A5);
        step(1'b0, 10'd0, 32'h0);
        check("addr0_intact", word_for(0));

        // Asynchronous reset between edges, with a write attempted while held.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_q", 32'h0);
        we   = 1'b1;
        addr = 10'd5;
        data = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        check("reset_write_blocked_q", 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        we    = 1'b0;
        @(posedge clk);
        #1;
        check("after_reset_read5", 32'h0000_0001);
        step(1'b0, 10'd1023, 32'h0);
        check("after_reset_read1023", 32'hA5A5_A5A5);
        step(1'b0, 10'd31, 32'h0);
        check("after_reset_read31", word_for(31));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
